// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and its bench.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int          REG_W    = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam int          STATE_W  = 2;
  localparam int          CTRL_W   = 6;

  // $0 is hardwired, so a load targeting it never creates a real dependency.
  function automatic logic load_use_hit(input logic             memread,
                                        input logic [REG_W-1:0] ex_rt,
                                        input logic [REG_W-1:0] id_rs,
                                        input logic [REG_W-1:0] id_rt,
                                        input logic             uses_rt);
    return memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sources and pipeline control bundle between the datapath and the sequencer.
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic               start_i;
  logic [REG_W-1:0]   id_rs_i;
  logic [REG_W-1:0]   id_rt_i;
  logic               id_uses_rt_i;
  logic               ex_memread_i;
  logic [REG_W-1:0]   ex_rt_i;
  logic               branch_taken_i;
  logic               jump_i;
  logic               mem_req_i;
  logic               mem_ready_i;
  logic               pc_write_o;
  logic               ifid_write_o;
  logic               ifid_flush_o;
  logic               idex_bubble_o;
  logic               pipe_hold_o;
  logic               memwb_bubble_o;
  logic [STATE_W-1:0] state_o;
  logic               err_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [CNT_W-1:0]   flush_cnt_o;
  logic [CNT_W-1:0]   wait_cnt_o;

  modport master (
    output start_i, id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
           branch_taken_i, jump_i, mem_req_i, mem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           memwb_bubble_o, state_o, err_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
  );

  modport slave (
    input  start_i, id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
           branch_taken_i, jump_i, mem_req_i, mem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           memwb_bubble_o, state_o, err_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))
      cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer beside ID: memory wait > load-use > branch/jump flush.
// Optional event counters are built only when PIPE_PERF_CNT_EN is defined.
//
// state       | meaning
// ST_IDLE     | pipeline frozen, waiting for start_i
// ST_RUN      | normal issue; load-use stalls and flushes resolved here
// ST_MEM_WAIT | data memory busy; whole pipeline frozen until mem_ready_i
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] wait_tmr_q;
  logic             err_q;
  logic             load_use;
  logic             mem_busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    bus.pc_write_o     = 1'b0;
    bus.ifid_write_o   = 1'b0;
    bus.ifid_flush_o   = 1'b0;
    bus.idex_bubble_o  = 1'b0;
    bus.pipe_hold_o    = 1'b0;
    bus.memwb_bubble_o = 1'b0;
    load_use = load_use_hit(bus.ex_memread_i, bus.ex_rt_i, bus.id_rs_i,
                            bus.id_rt_i, bus.id_uses_rt_i);
    mem_busy = 1'b0;

    if (!bus.start_i) begin
      state_d         = ST_IDLE;
      bus.pipe_hold_o = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d         = ST_RUN;
          bus.pipe_hold_o = 1'b1;
        end
        ST_RUN, ST_MEM_WAIT: begin
          mem_busy = !bus.mem_ready_i &&
                     ((state_q == ST_MEM_WAIT) || bus.mem_req_i);
          if (mem_busy) begin
            state_d            = ST_MEM_WAIT;
            bus.pipe_hold_o    = 1'b1;
            bus.memwb_bubble_o = 1'b1;
          end else begin
            state_d = ST_RUN;
            // A stalled branch compares a stale operand; let it re-resolve next cycle.
            if (load_use) begin
              bus.idex_bubble_o = 1'b1;
            end else begin
              bus.pc_write_o   = 1'b1;
              bus.ifid_write_o = 1'b1;
              bus.ifid_flush_o = bus.branch_taken_i || bus.jump_i;
            end
          end
        end
        default: begin
          state_d         = ST_IDLE;
          bus.pipe_hold_o = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_tmr_q <= '0;
      err_q      <= 1'b0;
    end else if (mem_busy && (state_q == ST_MEM_WAIT)) begin
      if (wait_tmr_q != TMR_MAX)
        wait_tmr_q <= wait_tmr_q + 1'b1;
      if (wait_tmr_q == TMR_LAST)
        err_q <= 1'b1;
    end else begin
      wait_tmr_q <= '0;
    end
  end

  assign bus.state_o = state_q;
  assign bus.err_o   = err_q;

`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (bus.idex_bubble_o),
    .cnt_o   (bus.stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (bus.ifid_flush_o),
    .cnt_o   (bus.flush_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (state_q == ST_MEM_WAIT),
    .cnt_o   (bus.wait_cnt_o)
  );
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
  assign bus.wait_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 32;

  // ctrl bit order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble}
  localparam logic [5:0] C_IDLE  = 6'b000010;
  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_FLUSH = 6'b111000;
  localparam logic [5:0] C_MEM   = 6'b000011;

  typedef struct {
    string            name;
    logic [1:0]       st;
    logic [5:0]       ctrl;
    logic             err;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic [CNT_W-1:0] wc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt(input int v);
`ifdef PIPE_PERF_CNT_EN
    return CNT_W'(v);
`else
    return (v != 0) ? '0 : '0;
`endif
  endfunction

  task automatic expect_cyc(input string name, input logic [1:0] st, input logic [5:0] ctrl,
                            input logic err, input int sc, input int fc, input int wc);
    exp_t e;
    e.name = name;
    e.st   = st;
    e.ctrl = ctrl;
    e.err  = err;
    e.sc   = cnt(sc);
    e.fc   = cnt(fc);
    e.wc   = cnt(wc);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
               bus.idex_bubble_o, bus.pipe_hold_o, bus.memwb_bubble_o};
        checks++;
        if ({bus.state_o, bus.err_o} !== {e.st, e.err}) begin
          errors++;
          $display("FAIL %s state/err: got state=%0d err=%0b, want state=%0d err=%0b",
                   e.name, bus.state_o, bus.err_o, e.st, e.err);
        end
        checks++;
        if (act !== e.ctrl) begin
          errors++;
          $display("FAIL %s ctrl: got %b, want %b", e.name, act, e.ctrl);
        end
        checks++;
        if ({bus.stall_cnt_o, bus.flush_cnt_o, bus.wait_cnt_o} !== {e.sc, e.fc, e.wc}) begin
          errors++;
          $display("FAIL %s counters: got stall=%0d flush=%0d wait=%0d, want %0d %0d %0d",
                   e.name, bus.stall_cnt_o, bus.flush_cnt_o, bus.wait_cnt_o,
                   e.sc, e.fc, e.wc);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n              = 1'b0;
    bus.start_i        = 1'b0;
    bus.id_rs_i        = '0;
    bus.id_rt_i        = '0;
    bus.id_uses_rt_i   = 1'b0;
    bus.ex_memread_i   = 1'b0;
    bus.ex_rt_i        = '0;
    bus.branch_taken_i = 1'b0;
    bus.jump_i         = 1'b0;
    bus.mem_req_i      = 1'b0;
    bus.mem_ready_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    expect_cyc("reset",      2'd0, C_IDLE, 1'b0, 0, 0, 0);
    bus.start_i = 1'b1;
    expect_cyc("idle_start", 2'd0, C_IDLE, 1'b0, 0, 0, 0);
    expect_cyc("run",        2'd1, C_RUN,  1'b0, 0, 0, 0);

    // lw $8 in EX, add $9,$8,$8 in ID
    bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd8;
    bus.id_rs_i = 5'd8; bus.id_rt_i = 5'd8; bus.id_uses_rt_i = 1'b1;
    expect_cyc("lu_stall",   2'd1, C_STALL, 1'b0, 0, 0, 0);
    bus.ex_memread_i = 1'b0;
    expect_cyc("lu_release", 2'd1, C_RUN,   1'b0, 1, 0, 0);

    // load to $0 never stalls
    bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd0; bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0;
    expect_cyc("lu_zero",    2'd1, C_RUN,   1'b0, 1, 0, 0);
    bus.ex_rt_i = 5'd7; bus.id_rs_i = 5'd1; bus.id_rt_i = 5'd7; bus.id_uses_rt_i = 1'b0;
    expect_cyc("lu_rt_unused", 2'd1, C_RUN, 1'b0, 1, 0, 0);
    bus.id_uses_rt_i = 1'b1;
    expect_cyc("lu_rt",      2'd1, C_STALL, 1'b0, 1, 0, 0);
    bus.ex_memread_i = 1'b0; bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0;
    expect_cyc("after_rt",   2'd1, C_RUN,   1'b0, 2, 0, 0);

    // taken branch with load-use on rs: stall first, flush next cycle
    bus.branch_taken_i = 1'b1; bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd5;
    bus.id_rs_i = 5'd5; bus.id_rt_i = 5'd3; bus.id_uses_rt_i = 1'b0;
    expect_cyc("br_lu",      2'd1, C_STALL, 1'b0, 2, 0, 0);
    bus.ex_memread_i = 1'b0;
    expect_cyc("br_flush",   2'd1, C_FLUSH, 1'b0, 3, 0, 0);
    bus.branch_taken_i = 1'b0;
    expect_cyc("post_flush", 2'd1, C_RUN,   1'b0, 3, 1, 0);
    bus.jump_i = 1'b1;
    expect_cyc("jump",       2'd1, C_FLUSH, 1'b0, 3, 1, 0);
    bus.jump_i = 1'b0;
    expect_cyc("post_jump",  2'd1, C_RUN,   1'b0, 3, 2, 0);

    // memory wait outranks load-use and jump; ready after 3 low cycles
    bus.mem_req_i = 1'b1; bus.mem_ready_i = 1'b0; bus.jump_i = 1'b1;
    bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd4; bus.id_rs_i = 5'd4;
    expect_cyc("mem_req",    2'd1, C_MEM, 1'b0, 3, 2, 0);
    bus.jump_i = 1'b0; bus.ex_memread_i = 1'b0;
    expect_cyc("wait1",      2'd2, C_MEM, 1'b0, 3, 2, 0);
    expect_cyc("wait2",      2'd2, C_MEM, 1'b0, 3, 2, 1);
    bus.mem_ready_i = 1'b1;
    expect_cyc("ready",      2'd2, C_RUN, 1'b0, 3, 2, 2);
    bus.mem_req_i = 1'b0; bus.mem_ready_i = 1'b0;
    expect_cyc("post_mem",   2'd1, C_RUN, 1'b0, 3, 2, 3);

    // start_i low freezes immediately and parks in IDLE
    bus.start_i = 1'b0;
    expect_cyc("stop",       2'd1, C_IDLE, 1'b0, 3, 2, 3);
    expect_cyc("stopped",    2'd0, C_IDLE, 1'b0, 3, 2, 3);
    bus.start_i = 1'b1;
    expect_cyc("restart",    2'd0, C_IDLE, 1'b0, 3, 2, 3);
    expect_cyc("rerun",      2'd1, C_RUN,  1'b0, 3, 2, 3);

    // timeout: ready never arrives, err after 4 wait cycles
    bus.mem_req_i = 1'b1;
    expect_cyc("to_req",     2'd1, C_MEM, 1'b0, 3, 2, 3);
    expect_cyc("to_w1",      2'd2, C_MEM, 1'b0, 3, 2, 3);
    expect_cyc("to_w2",      2'd2, C_MEM, 1'b0, 3, 2, 4);
    expect_cyc("to_w3",      2'd2, C_MEM, 1'b0, 3, 2, 5);
    expect_cyc("to_w4",      2'd2, C_MEM, 1'b0, 3, 2, 6);
    expect_cyc("to_err",     2'd2, C_MEM, 1'b1, 3, 2, 7);
    rst_n = 1'b0; bus.mem_req_i = 1'b0;
    expect_cyc("rst",        2'd0, C_IDLE, 1'b0, 0, 0, 0);
    rst_n = 1'b1;
    expect_cyc("rst_idle",   2'd0, C_IDLE, 1'b0, 0, 0, 0);
    expect_cyc("rst_run",    2'd1, C_RUN,  1'b0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
